// File: rtl/gray_pkg.sv
// Definitions shared by the gray code producer and its consumers:
// monitor FSM encoding and default word widths.
package gray_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam int unsigned GRAY_BITS_DEFAULT = 8;
    localparam int unsigned ERR_BITS_DEFAULT  = 8;

endpackage

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary decode; the MSB passes straight through and
// each lower bit is the running XOR of the gray bits above and including it.
module gray_to_binary #(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] i_gray,
    output logic [BITS-1:0] o_binary
);

    always_comb begin
        o_binary           = '0;
        o_binary[BITS-1]   = i_gray[BITS-1];
        for (int unsigned k = 1; k < BITS; k++) begin
            o_binary[BITS-1-k] = o_binary[BITS-k] ^ i_gray[BITS-1-k];
        end
    end

endmodule

// File: rtl/gray_code_monitor.sv
// Synchronises an asynchronous gray code word, decodes it and classifies each
// accepted sample against the previous one as hold, step up/down or error.
module gray_code_monitor
    import gray_pkg::*;
#(
    parameter int unsigned BITS     = GRAY_BITS_DEFAULT,
    parameter int unsigned ERR_BITS = ERR_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITS-1:0]     gray_in,
    input  logic                clear,
    output logic [BITS-1:0]     binary_out,
    output logic                step_up,
    output logic                step_down,
    output logic                wrap,
    output logic                error,
    output logic                error_sticky,
    output logic [ERR_BITS-1:0] err_count
);

    logic [BITS-1:0]     r_sync1;
    logic [BITS-1:0]     r_sync2;
    logic [BITS-1:0]     r_ref;
    logic [ERR_BITS-1:0] r_err_count;
    logic                r_step_up;
    logic                r_step_down;
    logic                r_wrap;
    logic                r_error;
    logic                r_sticky;
    state_t              r_state;

    logic [BITS-1:0]     w_decoded;
    logic [BITS-1:0]     w_diff;
    logic                w_diff_one;
    logic                w_diff_ones;
    logic                w_tracking;
    logic                w_step_up;
    logic                w_step_down;
    logic                w_wrap;
    logic                w_error;
    logic                w_ref_load;
    logic [ERR_BITS-1:0] w_err_count_next;
    state_t              w_state_next;

    // Synchronizer runs free of clear so a pending change is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gray_in;
            r_sync2 <= r_sync1;
        end
    end

    gray_to_binary #(
        .BITS(BITS)
    ) u_decode (
        .i_gray   (r_sync2),
        .o_binary (w_decoded)
    );

    always_comb begin
        w_diff      = w_decoded - r_ref;
        w_diff_one  = (w_diff == BITS'(1));
        w_diff_ones = (w_diff == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACQUIRE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ACQUIRE;
        end else begin
            case (r_state)
                ACQUIRE: w_state_next = TRACK;
                TRACK,
                FAULT:   if (w_error) w_state_next = FAULT;
                default: w_state_next = ACQUIRE;
            endcase
        end
    end

    // diff==1 is tested first so that a 1-bit word resolves to step_up.
    always_comb begin
        w_tracking       = !clear && ((r_state == TRACK) || (r_state == FAULT));
        w_step_up        = w_tracking && w_diff_one;
        w_step_down      = w_tracking && !w_diff_one && w_diff_ones;
        w_error          = w_tracking && (w_diff != '0) && !w_diff_one && !w_diff_ones;
        w_wrap           = w_step_up && (r_ref == '1);
        w_ref_load       = (!clear && (r_state == ACQUIRE)) || w_step_up
                           || w_step_down || w_error;
        w_err_count_next = r_err_count;
        if (clear) begin
            w_err_count_next = '0;
        end else if (w_error && (r_err_count != '1)) begin
            w_err_count_next = r_err_count + ERR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref       <= '0;
            r_err_count <= '0;
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_wrap      <= 1'b0;
            r_error     <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            if (w_ref_load) begin
                r_ref <= w_decoded;
            end
            r_err_count <= w_err_count_next;
            r_step_up   <= w_step_up;
            r_step_down <= w_step_down;
            r_wrap      <= w_wrap;
            r_error     <= w_error;
            r_sticky    <= (w_state_next == FAULT);
        end
    end

    assign binary_out   = r_ref;
    assign step_up      = r_step_up;
    assign step_down    = r_step_down;
    assign wrap         = r_wrap;
    assign error        = r_error;
    assign error_sticky = r_sticky;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_gray_code_monitor.sv
// Directed bench for gray_code_monitor with a behavioural reference model
// compared every cycle, plus literal checkpoints per scenario.
module tb_gray_code_monitor;

    logic       clk;
    logic       rst_n;
    logic [7:0] gray_in;
    logic       clear;
    logic [7:0] binary_out;
    logic       step_up;
    logic       step_down;
    logic       wrap;
    logic       error;
    logic       error_sticky;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    gray_code_monitor #(
        .BITS     (8),
        .ERR_BITS (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gray_in      (gray_in),
        .clear        (clear),
        .binary_out   (binary_out),
        .step_up      (step_up),
        .step_down    (step_down),
        .wrap         (wrap),
        .error        (error),
        .error_sticky (error_sticky),
        .err_count    (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each binary bit is the parity of the gray bits at and above it.
    function automatic int m_dec(input logic [7:0] g);
        int b = 0;
        for (int i = 0; i < 8; i++) begin
            if (^(g >> i)) b += (1 << i);
        end
        return b;
    endfunction

    int m_s1 = 0, m_s2 = 0, m_ref = 0, m_cnt = 0;
    bit m_acq = 1, m_sticky = 0;
    bit m_up = 0, m_down = 0, m_wrap = 0, m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_ref = 0; m_cnt = 0;
            m_acq = 1; m_sticky = 0;
            m_up = 0; m_down = 0; m_wrap = 0; m_err = 0;
        end else begin
            int dec;
            int diff;
            dec = m_dec(8'(m_s2));
            diff = (dec - m_ref + 256) % 256;
            m_up = 0; m_down = 0; m_wrap = 0; m_err = 0;
            if (clear) begin
                m_acq = 1; m_sticky = 0; m_cnt = 0;
            end else if (m_acq) begin
                m_ref = dec; m_acq = 0;
            end else if (diff == 1) begin
                m_up = 1; m_wrap = (m_ref == 255); m_ref = dec;
            end else if (diff == 255) begin
                m_down = 1; m_ref = dec;
            end else if (diff != 0) begin
                m_err = 1; m_sticky = 1; m_ref = dec;
                if (m_cnt < 255) m_cnt++;
            end
            m_s2 = m_s1;
            m_s1 = int'(gray_in);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    int cnt_up = 0, cnt_down = 0, cnt_wrap = 0, cnt_err = 0;

    always @(negedge clk) begin
        check("binary_out", 32'(binary_out), 32'(m_ref));
        check("step_up", 32'(step_up), 32'(m_up));
        check("step_down", 32'(step_down), 32'(m_down));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("error", 32'(error), 32'(m_err));
        check("error_sticky", 32'(error_sticky), 32'(m_sticky));
        check("err_count", 32'(err_count), 32'(m_cnt));
        cnt_up   += int'(step_up);
        cnt_down += int'(step_down);
        cnt_wrap += int'(wrap);
        cnt_err  += int'(error);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int s_up, s_down, s_wrap, s_err;
    task automatic snap();
        s_up = cnt_up; s_down = cnt_down; s_wrap = cnt_wrap; s_err = cnt_err;
    endtask

    initial begin
        rst_n   = 1'b1;
        clear   = 1'b0;
        gray_in = 8'h00;
        #1 rst_n = 1'b0;
        cyc(3);
        check("reset_binary_out", 32'(binary_out), 0);
        check("reset_err_count", 32'(err_count), 0);
        check("reset_sticky", 32'(error_sticky), 0);
        rst_n = 1'b1;
        cyc(6);
        check("acquire_no_pulse", 32'(cnt_up + cnt_down + cnt_err), 0);

        snap();
        gray_in = 8'h01; cyc(4);
        check("count_bin1", 32'(binary_out), 1);
        gray_in = 8'h03; cyc(4);
        check("count_bin2", 32'(binary_out), 2);
        gray_in = 8'h02; cyc(4);
        check("count_bin3", 32'(binary_out), 3);
        check("count_three_up", 32'(cnt_up - s_up), 3);
        check("count_no_error", 32'(cnt_err - s_err), 0);

        gray_in = 8'h80; cyc(4);
        clear = 1'b1; cyc(1); clear = 1'b0;
        cyc(3);
        check("reacquire_255", 32'(binary_out), 255);
        snap();
        gray_in = 8'h00; cyc(4);
        check("wrap_step_up", 32'(cnt_up - s_up), 1);
        check("wrap_pulse", 32'(cnt_wrap - s_wrap), 1);
        check("wrap_bin0", 32'(binary_out), 0);

        gray_in = 8'h01; cyc(4);
        gray_in = 8'h03; cyc(4);
        snap();
        gray_in = 8'h01; cyc(4);
        check("down_pulse", 32'(cnt_down - s_down), 1);
        check("down_no_wrap", 32'(cnt_wrap - s_wrap), 0);
        check("down_bin1", 32'(binary_out), 1);

        snap();
        gray_in = 8'h06; cyc(4);
        check("jump_error", 32'(cnt_err - s_err), 1);
        check("jump_err_count", 32'(err_count), 1);
        check("jump_sticky", 32'(error_sticky), 1);
        check("jump_bin4", 32'(binary_out), 4);
        snap();
        gray_in = 8'h07; cyc(4);
        gray_in = 8'h06; cyc(4);
        check("fault_up", 32'(cnt_up - s_up), 1);
        check("fault_down", 32'(cnt_down - s_down), 1);
        check("fault_sticky_held", 32'(error_sticky), 1);

        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 8'h00 : 8'h06;
            cyc(1);
        end
        cyc(4);
        check("saturated_count", 32'(err_count), 255);
        clear = 1'b1; cyc(1); clear = 1'b0;
        check("clear_count", 32'(err_count), 0);
        check("clear_sticky", 32'(error_sticky), 0);
        snap();
        cyc(5);
        check("post_clear_no_pulse", 32'((cnt_up - s_up) + (cnt_down - s_down) + (cnt_err - s_err)), 0);
        check("post_clear_bin4", 32'(binary_out), 4);

        snap();
        gray_in = 8'h00; cyc(2);
        clear = 1'b1; cyc(1); clear = 1'b0;
        cyc(4);
        check("clear_beats_error", 32'(cnt_err - s_err), 0);
        check("clear_beats_count", 32'(err_count), 0);
        check("clear_beats_bin0", 32'(binary_out), 0);

        gray_in = 8'h01;
        @(posedge clk);
        #2 rst_n = 1'b0;
        gray_in = 8'h00;
        #1;
        check("midreset_outputs", 32'({binary_out, step_up, step_down, wrap, error, error_sticky, err_count}), 0);
        cyc(3);
        rst_n = 1'b1;
        snap();
        cyc(8);
        check("after_reset_no_pulse", 32'((cnt_up - s_up) + (cnt_down - s_down) + (cnt_err - s_err)), 0);
        check("after_reset_bin0", 32'(binary_out), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/gray_code_monitor.md
GRAY_CODE_MONITOR -- requirements
Module: gray_code_monitor

Interface
REQ-001 SHALL have parameter BITS, default 8, width of the gray code word consumed.
REQ-002 SHALL have parameter ERR_BITS, default 8, width of the saturating error counter.
REQ-003 SHALL have port clk  input  1  single clock; every register is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port gray_in  input  BITS  gray code word from the upstream gray code counter; treated as asynchronous.
REQ-006 SHALL have port clear  input  1  synchronous clear of error state and counters.
REQ-007 SHALL have port binary_out  output  BITS  decoded binary value of the last accepted sample.
REQ-008 SHALL have port step_up  output  1  one-cycle pulse; accepted value = previous + 1 (mod 2^BITS).
REQ-009 SHALL have port step_down  output  1  one-cycle pulse; accepted value = previous - 1 (mod 2^BITS).
REQ-010 SHALL have port wrap  output  1  one-cycle pulse coincident with step_up from all-ones to 0.
REQ-011 SHALL have port error  output  1  one-cycle pulse when a sample differs by neither 0 nor ±1.
REQ-012 SHALL have port error_sticky  output  1  high while the FSM is in FAULT.
REQ-013 SHALL have port err_count  output  ERR_BITS  number of errors; saturates at all-ones.

Function
REQ-014 SHALL pass gray_in through a 2-flop synchronizer (sync1, sync2) before any use.
REQ-015 SHALL convert sync2 to binary combinationally: b[BITS-1]=g[BITS-1]; b[i]=b[i+1]^g[i].
REQ-016 SHALL hold a reference register ref, equal to binary_out.
REQ-017 SHALL compute diff = (decoded - ref) mod 2^BITS, BITS bits wide.
REQ-018 SHALL update all outputs on the edge after the value reaches sync2, i.e. three clk edges after gray_in changes.
REQ-019 SHALL implement FSM states ACQUIRE, TRACK and FAULT.
REQ-020 In ACQUIRE, SHALL load ref with the decoded value, raise no pulses, and go to TRACK next cycle.
REQ-021 In TRACK or FAULT with diff==0, SHALL raise no pulse and keep ref unchanged.
REQ-022 In TRACK or FAULT with diff==1, SHALL pulse step_up, load ref, and stay in the current state.
REQ-023 In TRACK or FAULT with diff==all-ones, SHALL pulse step_down, load ref, and stay in the current state.
REQ-024 In TRACK or FAULT with any other diff, SHALL pulse error, increment err_count, load ref (resynchronise to the new value), and go to FAULT.
REQ-025 SHALL pulse wrap only when step_up fires with ref==all-ones; no wrap on step_down from 0.
REQ-026 SHALL keep err_count at all-ones on further errors once saturated.
REQ-027 SHALL have step_up, step_down and error mutually exclusive in any cycle.
REQ-028 On clear, SHALL force the FSM to ACQUIRE, zero err_count, drop error_sticky and suppress pulses that cycle.
REQ-029 When clear and a diff error coincide, clear SHALL win.
REQ-030 SHALL not reset or stall the synchronizer on clear.
REQ-031 For BITS=1, SHALL treat diff==1 as step_up (step_up and step_down are indistinguishable; step_up wins).

Reset
REQ-032 While rst_n is low, SHALL asynchronously reset sync1, sync2, ref and binary_out to 0.
REQ-033 While rst_n is low, SHALL asynchronously reset all pulses, error_sticky and err_count to 0.
REQ-034 While rst_n is low, SHALL hold the FSM in ACQUIRE.
REQ-035 On reset release, SHALL start acquisition on the first edge after deassertion; the first accepted sample SHALL produce no pulse.
REQ-036 SHALL abandon any in-progress classification when reset is asserted mid-operation, with no residual pulse after release.

Structure
REQ-037 SHALL take the FSM state encoding (2-bit, ACQUIRE=0, TRACK=1, FAULT=2) from shared package gray_pkg.
REQ-038 SHALL take from gray_pkg any default width constants shared with the counter side.
REQ-039 SHALL instantiate the decode in sub-module gray_to_binary (parameter BITS), reusable by other consumers.
REQ-040 SHALL keep the monitor within 120-400 lines including the sub-module.

Verification
REQ-041 Reset, then drive gray_in 0x00->0x01->0x03->0x02 spaced 4 cycles -> binary_out 0,1,2,3; three step_up pulses; no error.
REQ-042 Drive gray 0x80 (bin 255) then 0x00 -> step_up and wrap in the same cycle, binary_out=0.
REQ-043 Drive gray 0x03 (bin 2) then 0x01 (bin 1) -> single step_down, no wrap.
REQ-044 Drive gray 0x01 then 0x06 (bin 4) -> error pulse, err_count=1, error_sticky=1; next ±1 steps still pulse in FAULT.
REQ-045 Inject 300 illegal jumps -> err_count saturates at 255; then assert clear -> err_count=0, error_sticky=0, first sample after clear produces no pulse.
REQ-046 Assert rst_n low mid-sequence while a change is in the synchronizer -> all outputs 0 immediately; no pulse after release.
